// File: rtl/uart_rx_os_if.sv
// Receive-word stream between uart_rx_os and its consumer.
// master = receiver side, slave = consumer side.
interface uart_rx_os_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] o_rx_data;
    logic                  o_parity_err;
    logic                  o_frame_err;
    logic                  o_rx_valid;
    logic                  i_rx_ready;

    modport master (
        output o_rx_data,
        output o_parity_err,
        output o_frame_err,
        output o_rx_valid,
        input  i_rx_ready
    );

    modport slave (
        input  o_rx_data,
        input  o_parity_err,
        input  o_frame_err,
        input  o_rx_valid,
        output i_rx_ready
    );
endinterface

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority voting,
// runtime baud divisor and a show-ahead status FIFO.
module uart_rx_os #(
    parameter int DATA_WIDTH  = 8,
    parameter int PARITY_ON   = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4,
    parameter int DIV_WIDTH   = 16
) (
    input  logic                        i_clk_sys,
    input  logic                        i_rst,
    input  logic [DIV_WIDTH-1:0]        i_baud_div,
    input  logic                        i_uart_rx,
    uart_rx_os_if.master                rx_if,
    output logic                        o_break,
    output logic                        o_overrun,
    input  logic                        i_clr_ovr,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int EW = DATA_WIDTH + 2;
    localparam logic [PW:0] FULL_LVL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_e;

    logic [1:0]            sync_q;
    logic                  rx_s;
    logic [DIV_WIDTH-1:0]  div_cnt_q;
    logic                  tick;
    state_e                state_q, state_d;
    logic [3:0]            os_cnt_q, os_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  s7_q, s8_q;
    logic                  par_err_q, par_err_d;
    logic                  par_vote_q, par_vote_d;
    logic                  stop0_q, stop0_d;
    logic                  ferr_q, ferr_d;
    logic                  vote, vote_tick, wrap;
    logic                  push, brk;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PW:0]           level_q, level_d;
    logic                  full, pop, wr_en, ovr_set;
    logic [EW-1:0]         head;

    assign rx_s      = sync_q[1];
    assign tick      = (div_cnt_q == i_baud_div);
    assign vote      = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);
    assign vote_tick = tick && (os_cnt_q == 4'd9);
    assign wrap      = tick && (os_cnt_q == 4'd15);

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        par_err_d  = par_err_q;
        par_vote_d = par_vote_q;
        stop0_d    = stop0_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        brk        = 1'b0;
        if (tick && state_q != S_IDLE && state_q != S_WAIT_HIGH)
            os_cnt_d = os_cnt_q + 4'd1;
        unique case (state_q)
            S_IDLE: begin
                if (tick && !rx_s) begin
                    state_d    = S_START;
                    os_cnt_d   = 4'd0;
                    bit_cnt_d  = 4'd0;
                    stop_cnt_d = 1'b0;
                    par_err_d  = 1'b0;
                    par_vote_d = 1'b0;
                    stop0_d    = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (vote_tick && vote)
                    state_d = S_IDLE;
                else if (wrap)
                    state_d = S_DATA;
            end
            S_DATA: begin
                if (vote_tick) begin
                    shreg_d   = {vote, shreg_q[DATA_WIDTH-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (wrap && bit_cnt_q == 4'(DATA_WIDTH))
                    state_d = (PARITY_ON != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (vote_tick) begin
                    par_vote_d = vote;
                    par_err_d  = ((^shreg_q) ^ vote) != 1'(PARITY_TYPE);
                end
                if (wrap)
                    state_d = S_STOP;
            end
            S_STOP: begin
                if (vote_tick) begin
                    ferr_d = ferr_q | ~vote;
                    // Complete on the last stop vote so back-to-back frames re-arm early
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        push = 1'b1;
                        brk  = (shreg_q == '0)
                            && (PARITY_ON == 0 || !par_vote_q)
                            && (stop_cnt_q == 1'b0 ? !vote : !stop0_q);
                        state_d = brk ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        stop0_d    = vote;
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (tick && rx_s)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            sync_q     <= 2'b11;
            div_cnt_q  <= '0;
            state_q    <= S_IDLE;
            os_cnt_q   <= 4'd0;
            bit_cnt_q  <= 4'd0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            s7_q       <= 1'b1;
            s8_q       <= 1'b1;
            par_err_q  <= 1'b0;
            par_vote_q <= 1'b0;
            stop0_q    <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], i_uart_rx};
            div_cnt_q  <= tick ? '0 : div_cnt_q + 1'b1;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            par_err_q  <= par_err_d;
            par_vote_q <= par_vote_d;
            stop0_q    <= stop0_d;
            ferr_q     <= ferr_d;
            if (tick && os_cnt_q == 4'd7)
                s7_q <= rx_s;
            if (tick && os_cnt_q == 4'd8)
                s8_q <= rx_s;
        end
    end

    // A pop in the same cycle frees the slot, so a push at full still lands
    assign full    = (level_q == FULL_LVL);
    assign pop     = rx_if.o_rx_valid && rx_if.i_rx_ready;
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_comb begin
        level_d = level_q;
        if (wr_en && !pop)
            level_d = level_q + 1'b1;
        else if (pop && !wr_en)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge i_clk_sys or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            o_overrun <= 1'b0;
        end else begin
            level_q <= level_d;
            if (wr_en)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ovr_set)
                o_overrun <= 1'b1;
            else if (i_clr_ovr)
                o_overrun <= 1'b0;
        end
    end

    always_ff @(posedge i_clk_sys) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= {ferr_q | ~vote, par_err_q, shreg_q};
    end

    assign head               = mem_q[rd_ptr_q];
    assign rx_if.o_rx_valid   = (level_q != '0);
    assign rx_if.o_rx_data    = rx_if.o_rx_valid ? head[DATA_WIDTH-1:0] : '0;
    assign rx_if.o_parity_err = rx_if.o_rx_valid & head[DATA_WIDTH];
    assign rx_if.o_frame_err  = rx_if.o_rx_valid & head[DATA_WIDTH+1];
    assign o_break            = push & brk;
    assign o_fifo_level       = level_q;
endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver, parametrised successor to the team's fixed-baud receiver. It adds a runtime baud divisor and 16x oversampling with 3-sample majority voting. Each received word is stored in an output FIFO with per-word parity, framing and break status. The block sits between the board RX pin and any consumer using a valid/ready stream, for example a command parser or DMA.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9.
- PARITY_ON, 0: 1 = a parity bit follows the data.
- PARITY_TYPE, 0: 1 = odd parity, 0 = even parity.
- STOP_BITS, 1: 1 or 2 stop bits checked.
- FIFO_DEPTH, 4: output FIFO entries, power of 2, at least 2.
- DIV_WIDTH, 16: width of the baud divisor.

Ports:
- i_clk_sys in 1: system clock.
- i_rst in 1: reset, asynchronous, active-high.
- i_baud_div in DIV_WIDTH: oversample tick period minus 1, so the tick period is i_baud_div+1 clocks. Must be held static while a frame is in progress.
- i_uart_rx in 1: asynchronous serial input.
- o_rx_data out DATA_WIDTH: data at the FIFO head.
- o_parity_err out 1: head word parity mismatch. Always 0 when PARITY_ON=0.
- o_frame_err out 1: head word had at least one stop bit voted 0.
- o_rx_valid out 1: FIFO not empty.
- i_rx_ready in 1: consumer accepts the head word.
- o_break out 1: one-cycle pulse when a break is detected.
- o_overrun out 1: sticky; set when a word is dropped because the FIFO is full.
- i_clr_ovr in 1: clears o_overrun.
- o_fifo_level out clog2(FIFO_DEPTH)+1: current number of FIFO entries.

## Operation
- **Input synchroniser:** i_uart_rx passes through a 2-flop synchroniser, reset value 1, producing rx_s.
- **Tick generator:** div_cnt counts 0..i_baud_div and runs freely.
  - tick = (div_cnt == i_baud_div); div_cnt returns to 0 on tick.
  - i_baud_div=0 gives a tick every clock.
- **Oversample counter:** os_cnt (4 bits) advances on each tick while not in IDLE or WAIT_HIGH and wraps 15 to 0. Each wrap marks a bit boundary.
- **Majority vote:** rx_s is sampled on the ticks at os_cnt 7, 8 and 9. The vote is decided on the os_cnt 9 tick as at least 2 of the 3 samples.
- **FSM states and transitions:**
  - IDLE: on a tick with rx_s=0, go to START with os_cnt=0.
  - START: if the vote is 1 (false start), return to IDLE. Otherwise go to DATA at the bit boundary.
  - DATA: shift votes in LSB first into a shift register and increment bit_cnt. After DATA_WIDTH bits, go to PARITY if PARITY_ON, else STOP.
  - PARITY: compute par_err = (XOR of data bits ^ vote) != PARITY_TYPE.
  - STOP: frame_err is the OR of (vote==0) across the STOP_BITS stop bits.
  - Completion: on the vote tick of the last stop bit, push {frame_err, par_err, data}. Do not wait for the bit boundary. Go to IDLE, or to WAIT_HIGH if a break was detected.
  - WAIT_HIGH: on a tick with rx_s=1, go to IDLE.
- **Break:** all data votes 0, the parity vote 0 (if present), and the first stop vote 0. A break pulses o_break for one cycle coincident with the push. The word (data 0, frame_err=1) is still pushed.
- **FIFO push:** when the FIFO is full, the push is dropped and o_overrun is set. The FIFO contents are unchanged.
- **FIFO pop:** occurs when o_rx_valid && i_rx_ready.
  - Simultaneous push and pop when full: the pop frees a slot and the push is accepted, so the level is unchanged and o_overrun is not set.
  - Simultaneous push and pop when empty: only the push has effect.
- **Overrun clear:** i_clr_ovr clears o_overrun. If i_clr_ovr coincides with a new overrun event, o_overrun stays 1 (set wins).
- **Pointers:** pointers wrap modulo FIFO_DEPTH, and the level is 0..FIFO_DEPTH. The FIFO output is show-ahead: o_rx_data and the error flags reflect the head entry whenever o_rx_valid=1.

## Timing
- **Reset (asynchronous, active-high):**
  - State is IDLE; all counters are 0 and the FIFO is empty.
  - o_rx_valid=0, o_rx_data=0, o_parity_err=0, o_frame_err=0, o_break=0, o_overrun=0, o_fifo_level=0.
  - Asserting reset mid-frame discards the partial word and all FIFO contents.
- **Pin to detection:** 2 clocks from the pin to rx_s. Start detection resolves within one tick period.
- **Push latency:** the word is written on the clock edge ending the last-stop-vote tick cycle. o_rx_valid, o_fifo_level and the data are visible on the next cycle.
- **Pop:** takes effect on the clock edge where valid && ready. The next head word, or o_rx_valid=0, is visible on the following cycle.
- **Frame length:** (1 + DATA_WIDTH + PARITY_ON + STOP_BITS) * 16 ticks nominal. The receiver re-arms 6 ticks before the nominal frame end, which tolerates back-to-back frames and about ±4% baud mismatch.

## Test plan
Bench defaults: i_baud_div=3 (64 clocks/bit), DATA_WIDTH=8, PARITY_ON=1, PARITY_TYPE=0, STOP_BITS=1, FIFO_DEPTH=4.
- **Good frame:** send 0xA5 with parity 0 and stop 1 -> one word 0xA5, par_err=0, frame_err=0. o_rx_valid rises 1 cycle after the stop vote tick.
- **Parity and framing errors:** send 0x3C with parity 1 -> word 0x3C, par_err=1. Send 0x55 with stop bit 0 -> frame_err=1.
- **Noise rejection:**
  - Low glitch of 8 clocks on an idle line -> no word, FSM back in IDLE.
  - 4-clock high spike at os_cnt 8 inside a 0 data bit -> bit still received as 0.
- **Break:** hold the line low for 12 bit times, then return it high and send 0x81 -> o_break pulses once. The words received are 0x00 with frame_err=1, then 0x81 clean, with no extra words in between.
- **Overrun:** hold i_rx_ready=0 and send 5 words 0x01..0x05 -> level 4, o_overrun=1 after the 5th word. Then ready=1 pops 0x01..0x04 in order. i_clr_ovr clears the flag. Also check push and pop in the same cycle at full: level stays 4 and no overrun.
- **Reset mid-frame:** assert i_rst during DATA bit 3 -> all outputs at reset values. After release, 0x7E is received correctly.
